// File: rtl/fft4_twiddle_stage_ctrl.sv
// Radix-4 twiddle-multiply stage sequencer: walks group labels per frame,
// issues buffer reads and aligned datapath valid/label, meters issue against
// output-FIFO credits, tracks in-flight groups and checks result order.
module fft4_twiddle_stage_ctrl #(
    parameter int unsigned LABEL_W  = 11,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned PIPE_LAT = 6,
    parameter int unsigned CREDITS  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [LABEL_W-1:0] frame_len,
    output logic               rd_en,
    output logic [LABEL_W-1:0] rd_addr,
    output logic               dp_valid,
    output logic [LABEL_W-1:0] dp_lable,
    input  logic               dp_ready,
    input  logic [LABEL_W-1:0] dp_index,
    output logic               out_wr_en,
    input  logic               out_pop,
    output logic               busy,
    output logic               done,
    output logic               seq_err,
    output logic               start_err
);

    localparam int unsigned CNT_W = $clog2(CREDITS) + 1;
    localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);

    // The FIFO must be deep enough to cover a full read + datapath round trip.
    if ((CREDITS < PIPE_LAT + RD_LAT) || (RD_LAT < 1) || (RD_LAT > 4)) begin : g_cfg_check
        $error("fft4_twiddle_stage_ctrl: illegal RD_LAT/PIPE_LAT/CREDITS combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE,
        S_FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [LABEL_W-1:0] cnt_q, cnt_d;
    logic [LABEL_W-1:0] flen_q, flen_d;
    logic [LABEL_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               seq_err_q, seq_err_d;
    logic               accept;
    logic               vpipe_q [RD_LAT];
    logic [LABEL_W-1:0] lpipe_q [RD_LAT];

    assign rd_en     = (state_q == S_ISSUE) && (credits_q != '0);
    assign rd_addr   = cnt_q;
    assign dp_valid  = vpipe_q[RD_LAT-1];
    assign dp_lable  = lpipe_q[RD_LAT-1];
    assign out_wr_en = dp_ready && (state_q != S_IDLE);
    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);
    assign seq_err   = seq_err_q;
    assign start_err = start && (state_q != S_IDLE);

    // In-flight and credit counters; simultaneous inc/dec leaves both unchanged.
    always_comb begin
        inflight_d = inflight_q;
        credits_d  = credits_q;
        case ({rd_en, dp_ready})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        case ({rd_en, out_pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   if (credits_q < CREDITS_MAX) credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // FSM next state, label counter, expected-index tracker and sticky order error.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flen_d    = flen_q;
        exp_d     = exp_q;
        seq_err_d = seq_err_q;
        accept    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_FLUSH;
                end else if (rd_en && (cnt_q == flen_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_FLUSH;
                end else if (inflight_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FLUSH: begin
                if (inflight_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            cnt_d  = '0;
            flen_d = frame_len;
        end else if (rd_en) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept) begin
            exp_d     = '0;
            seq_err_d = 1'b0;
        end else if (dp_ready) begin
            exp_d = exp_q + 1'b1;
            if ((state_q == S_IDLE) || (dp_index != exp_q) || (inflight_q == '0)) begin
                seq_err_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            flen_q     <= '0;
            exp_q      <= '0;
            credits_q  <= CREDITS_MAX;
            inflight_q <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flen_q     <= flen_d;
            exp_q      <= exp_d;
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // Read-latency alignment shift of rd_en/rd_addr; never killed by abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vpipe_q[i] <= 1'b0;
                lpipe_q[i] <= '0;
            end
        end else begin
            vpipe_q[0] <= rd_en;
            lpipe_q[0] <= rd_addr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                lpipe_q[i] <= lpipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fft4_twiddle_stage_ctrl.sv
// Bench for fft4_twiddle_stage_ctrl: emulated datapath returns each valid
// label PIPE_LAT cycles later; frame-level expectations come from the spec.
module tb_fft4_twiddle_stage_ctrl;

    localparam int LW       = 11;
    localparam int RD_LAT   = 1;
    localparam int PIPE_LAT = 6;
    localparam int CREDITS  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dp_ready = 1'b0;
    logic          out_pop = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [LW-1:0] dp_index = '0;
    logic          rd_en, dp_valid, out_wr_en, busy, done, seq_err, start_err;
    logic [LW-1:0] rd_addr, dp_lable;

    fft4_twiddle_stage_ctrl #(
        .LABEL_W (LW),
        .RD_LAT  (RD_LAT),
        .PIPE_LAT(PIPE_LAT),
        .CREDITS (CREDITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .frame_len(frame_len),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .dp_valid (dp_valid),
        .dp_lable (dp_lable),
        .dp_ready (dp_ready),
        .dp_index (dp_index),
        .out_wr_en(out_wr_en),
        .out_pop  (out_pop),
        .busy     (busy),
        .done     (done),
        .seq_err  (seq_err),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [LW-1:0] lab;
    } ret_t;

    ret_t          dpq[$];
    int            iss_cyc[$];
    logic [LW-1:0] iss_addr[$];
    int            dpv_cyc[$];
    logic [LW-1:0] dpv_lab[$];
    int            rdy_cyc[$];
    int            cyc_n = 0;
    int            mcred = CREDITS;
    int            cred_viol = 0;
    int            wr_cnt, done_cnt, done_cyc, serr_cnt, serr_first, start_cyc;
    logic          done_serr;
    int            bump_at = -1;
    int            rdy_in_frame = 0;
    bit            inject_rdy = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    function automatic logic popv(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic clear_stats();
        iss_cyc.delete(); iss_addr.delete(); dpv_cyc.delete(); dpv_lab.delete(); rdy_cyc.delete();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; serr_cnt = 0; serr_first = -1;
        done_serr = 1'b0; rdy_in_frame = 0; cred_viol = 0;
    endtask

    // Record the finishing cycle, advance one clock, drive this cycle's inputs.
    task automatic tick(input logic st, input logic ab, input logic pp);
        ret_t r;
        if (rst_n) begin
            if (rd_en) begin
                iss_cyc.push_back(cyc_n);
                iss_addr.push_back(rd_addr);
                if (mcred <= 0) cred_viol++;
            end
            if (dp_valid) begin
                dpv_cyc.push_back(cyc_n);
                dpv_lab.push_back(dp_lable);
                dpq.push_back('{due: cyc_n + PIPE_LAT, lab: dp_lable});
            end
            if (dp_ready) rdy_cyc.push_back(cyc_n);
            if (out_wr_en) wr_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc_n; done_serr = seq_err; end
            if (start_err) serr_cnt++;
            if (seq_err && serr_first < 0) serr_first = cyc_n;
            if (rd_en && !out_pop) mcred--;
            else if (!rd_en && out_pop && mcred < CREDITS) mcred++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        start = st; abort = ab; out_pop = pp;
        dp_ready = 1'b0; dp_index = '0;
        if (inject_rdy) begin
            dp_ready = 1'b1;
            inject_rdy = 0;
        end else if (dpq.size() > 0 && dpq[0].due <= cyc_n) begin
            r = dpq.pop_front();
            dp_ready = 1'b1;
            dp_index = r.lab;
            if (rdy_in_frame == bump_at) dp_index = r.lab + 1'b1;
            rdy_in_frame++;
        end
        #1;
    endtask

    task automatic refill();
        repeat (CREDITS) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input int flen, input int pop_mode, input bit settle, output bit to);
        frame_len = LW'(flen);
        tick(1'b1, 1'b0, popv(pop_mode));
        clear_stats();
        start_cyc = cyc_n;
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            tick(1'b0, 1'b0, popv(pop_mode));
            if (done === 1'b1) begin to = 0; break; end
        end
        if (settle) tick(1'b0, 1'b0, popv(pop_mode));
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({rd_en, dp_valid, out_wr_en, busy, done, seq_err, start_err, rd_addr, dp_lable} !== '0)
            $display("FAIL reset_outputs: got %b%b%b%b%b%b%b addr=%0d lab=%0d, want all 0",
                     rd_en, dp_valid, out_wr_en, busy, done, seq_err, start_err, rd_addr, dp_lable);
        else n_pass++;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        mcred = CREDITS;
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({busy, rd_en} !== 2'b00) $display("FAIL reset_idle: busy/rd_en=%b, want 00", {busy, rd_en});
        else n_pass++;
    endtask

    task automatic test_reset_mid_issue();
        bit found = 0;
        frame_len = LW'(20);
        tick(1'b1, 1'b0, 1'b1);
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (rd_en === 1'b1 && rd_addr === LW'(5)) begin found = 1; break; end
        end
        n_checks++;
        if (!found) $display("FAIL mid_issue_reach: label 5 never issued, want issued");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_en, dp_valid, out_wr_en, busy, done, seq_err, start_err, rd_addr, dp_lable} !== '0)
            $display("FAIL mid_reset_outputs: got %b%b%b%b%b%b%b addr=%0d lab=%0d, want all 0",
                     rd_en, dp_valid, out_wr_en, busy, done, seq_err, start_err, rd_addr, dp_lable);
        else n_pass++;
        dpq.delete(); mcred = CREDITS; inject_rdy = 0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_credit_stall();
        int bad = 0;
        bit fin = 0;
        frame_len = LW'(31);
        tick(1'b1, 1'b0, 1'b0);
        clear_stats();
        start_cyc = cyc_n;
        repeat (40) tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (iss_cyc.size() !== 16) $display("FAIL stall_issue_count: got %0d, want 16", iss_cyc.size());
        else n_pass++;
        n_checks++;
        if (iss_addr.size() == 0 || iss_addr[0] !== LW'(0) || iss_cyc[0] !== start_cyc + 1)
            $display("FAIL post_reset_first_label: got size=%0d, want label 0 at cycle %0d", iss_addr.size(), start_cyc + 1);
        else n_pass++;
        n_checks++;
        if ({rd_en, busy} !== 2'b01) $display("FAIL stall_rd_en: rd_en/busy=%b, want 01", {rd_en, busy});
        else n_pass++;
        repeat (4) tick(1'b0, 1'b0, 1'b1);
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (iss_cyc.size() !== 20) $display("FAIL pop4_issue_count: got %0d, want 20", iss_cyc.size());
        else n_pass++;
        n_checks++;
        if (done_cnt !== 0) $display("FAIL stall_no_done: got %0d done pulses, want 0", done_cnt);
        else n_pass++;
        repeat (12) tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (done === 1'b1) begin fin = 1; break; end
        end
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (!fin) $display("FAIL stall_done_timeout: done never seen, want done");
        else n_pass++;
        for (int i = 0; i < iss_addr.size(); i++) if (iss_addr[i] !== LW'(i)) bad++;
        n_checks++;
        if (iss_addr.size() !== 32 || bad !== 0)
            $display("FAIL stall_labels: got %0d issues, %0d out of order, want 32 in order", iss_addr.size(), bad);
        else n_pass++;
        n_checks++;
        if (rdy_cyc.size() !== 32 || done_cnt !== 1 || done_cyc !== rdy_cyc[rdy_cyc.size()-1] + 1)
            $display("FAIL stall_done_timing: readies=%0d done_cnt=%0d done_cyc=%0d, want 32/1/last_ready+1",
                     rdy_cyc.size(), done_cnt, done_cyc);
        else n_pass++;
        n_checks++;
        if (cred_viol !== 0) $display("FAIL stall_credit_overrun: %0d issues without credit, want 0", cred_viol);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        bit to;
        refill();
        run_frame(7, 1, 1, to);
        n_checks++;
        if (to !== 1'b0 || iss_cyc.size() !== 8 || dpv_cyc.size() !== 8)
            $display("FAIL basic_counts: timeout=%0d issues=%0d valids=%0d, want 0/8/8", to, iss_cyc.size(), dpv_cyc.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < iss_cyc.size() && i < dpv_cyc.size(); i++) begin
            n_checks++;
            if (iss_addr[i] !== LW'(i) || iss_cyc[i] !== start_cyc + 1 + i || dpv_cyc[i] !== iss_cyc[i] + RD_LAT
                || dpv_lab[i] !== iss_addr[i])
                $display("FAIL basic_issue_%0d: addr=%0d cyc=%0d dpv_cyc=%0d lab=%0d, want addr=%0d cyc=%0d dpv_cyc=%0d lab=%0d",
                         i, iss_addr[i], iss_cyc[i], dpv_cyc[i], dpv_lab[i], i, start_cyc + 1 + i, start_cyc + 1 + i + RD_LAT, i);
            else n_pass++;
        end
        n_checks++;
        if (wr_cnt !== 8 || done_cnt !== 1 || rdy_cyc.size() !== 8 || done_cyc !== rdy_cyc[rdy_cyc.size()-1] + 1)
            $display("FAIL basic_done: wr=%0d done_cnt=%0d done_cyc=%0d, want 8/1/last_ready+1", wr_cnt, done_cnt, done_cyc);
        else n_pass++;
        n_checks++;
        if ({seq_err, busy} !== 2'b00) $display("FAIL basic_end_flags: seq_err/busy=%b, want 00", {seq_err, busy});
        else n_pass++;
    endtask

    task automatic test_abort();
        bit left = 0;
        frame_len = LW'(20);
        tick(1'b1, 1'b0, 1'b1);
        clear_stats();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== LW'(2)) $display("FAIL abort_third_issue: rd_en=%b addr=%0d, want 1/2", rd_en, rd_addr);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({rd_en, busy} !== 2'b01) $display("FAIL abort_flush: rd_en/busy=%b, want 01", {rd_en, busy});
        else n_pass++;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (busy === 1'b0) begin left = 1; break; end
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (!left || busy !== 1'b0) $display("FAIL abort_busy_drop: busy=%b, want 0", busy);
        else n_pass++;
        n_checks++;
        if (iss_cyc.size() !== 3 || wr_cnt !== 3 || done_cnt !== 0)
            $display("FAIL abort_counts: issues=%0d wr=%0d done=%0d, want 3/3/0", iss_cyc.size(), wr_cnt, done_cnt);
        else n_pass++;
    endtask

    task automatic test_order_error();
        bit to;
        bump_at = 2;
        run_frame(2, 1, 1, to);
        bump_at = -1;
        n_checks++;
        if (to !== 1'b0 || rdy_cyc.size() !== 3 || serr_first !== rdy_cyc[rdy_cyc.size()-1] + 1)
            $display("FAIL order_seq_err_set: timeout=%0d readies=%0d first_err=%0d, want 0/3/third_ready+1",
                     to, rdy_cyc.size(), serr_first);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_serr !== 1'b1 || seq_err !== 1'b1)
            $display("FAIL order_sticky: done=%0d err_at_done=%b err_now=%b, want 1/1/1", done_cnt, done_serr, seq_err);
        else n_pass++;
    endtask

    task automatic test_start_in_drain();
        bit found = 0;
        bit fin = 0;
        bit to;
        frame_len = LW'(10);
        tick(1'b1, 1'b0, 1'b1);
        clear_stats();
        tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (seq_err !== 1'b0) $display("FAIL start_clears_seq_err: got %b, want 0", seq_err);
        else n_pass++;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (busy === 1'b1 && rd_en === 1'b0) begin found = 1; break; end
        end
        tick(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (!found || start_err !== 1'b1) $display("FAIL drain_start_err: reached=%0d start_err=%b, want 1/1", found, start_err);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (start_err !== 1'b0) $display("FAIL drain_start_err_pulse: got %b, want 0", start_err);
        else n_pass++;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (done === 1'b1) begin fin = 1; break; end
        end
        tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (!fin || iss_cyc.size() !== 11 || done_cnt !== 1 || serr_cnt !== 1 || seq_err !== 1'b0)
            $display("FAIL drain_frame: fin=%0d issues=%0d done=%0d start_errs=%0d seq_err=%b, want 1/11/1/1/0",
                     fin, iss_cyc.size(), done_cnt, serr_cnt, seq_err);
        else n_pass++;
        run_frame(0, 1, 1, to);
        n_checks++;
        if (to !== 1'b0 || iss_cyc.size() !== 1 || iss_addr[0] !== LW'(0) || wr_cnt !== 1 || done_cnt !== 1
            || rdy_cyc.size() !== 1 || done_cyc !== rdy_cyc[0] + 1)
            $display("FAIL len0_frame: timeout=%0d issues=%0d wr=%0d done=%0d done_cyc=%0d, want 0/1/1/1/ready+1",
                     to, iss_cyc.size(), wr_cnt, done_cnt, done_cyc);
        else n_pass++;
    endtask

    task automatic test_idle_ready();
        inject_rdy = 1;
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dp_ready !== 1'b1 || out_wr_en !== 1'b0) $display("FAIL idle_ready_drop: out_wr_en=%b, want 0", out_wr_en);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (seq_err !== 1'b1) $display("FAIL idle_ready_seq_err: got %b, want 1", seq_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        run_frame(3, 1, 0, to1);
        n_checks++;
        if (to1 !== 1'b0 || done !== 1'b1) $display("FAIL b2b_first_done: timeout=%0d done=%b, want 0/1", to1, done);
        else n_pass++;
        run_frame(5, 1, 1, to2);
        n_checks++;
        if (to2 !== 1'b0 || iss_cyc.size() !== 6 || iss_cyc[0] !== start_cyc + 1 || serr_cnt !== 0
            || done_cnt !== 1 || seq_err !== 1'b0)
            $display("FAIL b2b_second: timeout=%0d issues=%0d first=%0d start_errs=%0d done=%0d seq_err=%b, want 0/6/%0d/0/1/0",
                     to2, iss_cyc.size(), iss_cyc[0], serr_cnt, done_cnt, seq_err, start_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        bit to;
        int flen, bad_lab, bad_lag;
        for (int k = 0; k < 6; k++) begin
            flen = int'($urandom_range(0, 40));
            refill();
            run_frame(flen, 2, 1, to);
            bad_lab = 0; bad_lag = 0;
            for (int i = 0; i < iss_addr.size(); i++) if (iss_addr[i] !== LW'(i)) bad_lab++;
            for (int i = 0; i < dpv_cyc.size() && i < iss_cyc.size(); i++)
                if (dpv_cyc[i] !== iss_cyc[i] + RD_LAT || dpv_lab[i] !== iss_addr[i]) bad_lag++;
            n_checks++;
            if (to !== 1'b0 || iss_addr.size() !== flen + 1 || bad_lab !== 0)
                $display("FAIL rand%0d_labels: timeout=%0d issues=%0d bad=%0d, want 0/%0d/0", k, to, iss_addr.size(), bad_lab, flen + 1);
            else n_pass++;
            n_checks++;
            if (dpv_cyc.size() !== flen + 1 || bad_lag !== 0)
                $display("FAIL rand%0d_align: valids=%0d bad=%0d, want %0d/0", k, dpv_cyc.size(), bad_lag, flen + 1);
            else n_pass++;
            n_checks++;
            if (wr_cnt !== flen + 1 || done_cnt !== 1 || rdy_cyc.size() !== flen + 1
                || done_cyc !== rdy_cyc[rdy_cyc.size()-1] + 1 || seq_err !== 1'b0 || cred_viol !== 0)
                $display("FAIL rand%0d_done: wr=%0d done=%0d done_cyc=%0d seq_err=%b overrun=%0d, want %0d/1/last_ready+1/0/0",
                         k, wr_cnt, done_cnt, done_cyc, seq_err, cred_viol, flen + 1);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        test_reset();
        test_reset_mid_issue();
        test_credit_stall();
        test_basic_frame();
        test_abort();
        test_order_error();
        test_start_in_drain();
        test_idle_ready();
        test_back_to_back();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
